autoref_scheduler: RTL and testbench



---
 rtl/autoref_scheduler.sv | 152 +++++++++++++++
 tb/tb_autoref_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/autoref_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : autoref_scheduler
// Purpose  : DRAM auto-refresh scheduler. It counts tREFI, banks up to
//            MAX_PEND owed REFs, requests REF slots and holds off commands
//            for tRFC. Define AREF_STATS_EN to enable the ref_count counter.
// Revision : 1.0 - initial release
// ============================================================================
module autoref_scheduler #(
  parameter int MAX_PEND = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        aref_en,
  input  logic [27:0] aref_interval,
  input  logic [27:0] trfc,
  input  logic        ref_ack,
  output logic        ref_req,
  output logic        ref_busy,
  output logic        ref_urgent,
  output logic        ref_overrun,
  output logic [3:0]  pend_cnt,
  output logic [15:0] ref_count
);

  localparam logic [3:0] c_max_pend = 4'(MAX_PEND);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_TRFC = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [27:0] icnt_q, icnt_d;
  logic [27:0] tcnt_q, tcnt_d;
  logic [3:0]  pend_q, pend_d;
  logic        req_q, req_d;
  logic        busy_q, busy_d;
  logic        ovr_q, ovr_d;
  logic        tick;
  logic        ack_acc;

  // The >= compare lets a lowered interval take effect immediately.
  always_comb begin
    tick   = 1'b0;
    icnt_d = icnt_q;
    if (!aref_en || (aref_interval == 28'd0)) begin
      icnt_d = 28'd0;
    end else if (icnt_q >= (aref_interval - 28'd1)) begin
      tick   = 1'b1;
      icnt_d = 28'd0;
    end else begin
      icnt_d = icnt_q + 28'd1;
    end
  end

  assign ack_acc = ref_ack && (state_q == ST_REQ);

  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (!aref_en) begin
      pend_d = 4'd0;
    end else if (tick && !ack_acc) begin
      if (pend_q == c_max_pend) begin
        ovr_d = 1'b1;
      end else begin
        pend_d = pend_q + 4'd1;
      end
    end else if (ack_acc && !tick && (pend_q != 4'd0)) begin
      pend_d = pend_q - 4'd1;
    end
  end

  // Next-state decisions look at pend_d so a tick is acted on without delay.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pend_d != 4'd0) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (ack_acc) begin
          tcnt_d  = (trfc == 28'd0) ? 28'd0 : (trfc - 28'd1);
          state_d = ST_TRFC;
        end else if (!aref_en) begin
          state_d = ST_IDLE;
        end
      end
      ST_TRFC: begin
        if (tcnt_q == 28'd0) begin
          state_d = (pend_d != 4'd0) ? ST_REQ : ST_IDLE;
        end else begin
          tcnt_d = tcnt_q - 28'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d  = (state_d == ST_REQ);
    busy_d = (state_d == ST_TRFC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      icnt_q  <= 28'd0;
      tcnt_q  <= 28'd0;
      pend_q  <= 4'd0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      icnt_q  <= icnt_d;
      tcnt_q  <= tcnt_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
    end
  end

`ifdef AREF_STATS_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q + {15'd0, ack_acc};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign ref_count = count_q;
`else
  assign ref_count = 16'd0;
`endif

  assign ref_req     = req_q;
  assign ref_busy    = busy_q;
  assign ref_urgent  = (pend_q == c_max_pend);
  assign ref_overrun = ovr_q;
  assign pend_cnt    = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_autoref_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_autoref_scheduler
// Purpose  : Directed self-checking bench for autoref_scheduler with a
//            cycle-level reference model; honours AREF_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_autoref_scheduler;

  localparam int MAXP = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        aref_en = 1'b0;
  logic [27:0] aref_interval = 28'd0;
  logic [27:0] trfc = 28'd0;
  logic        ref_ack = 1'b0;
  logic        ref_req, ref_busy, ref_urgent, ref_overrun;
  logic [3:0]  pend_cnt;
  logic [15:0] ref_count;

  autoref_scheduler #(.MAX_PEND(MAXP)) dut (
    .clk(clk), .rst(rst), .aref_en(aref_en), .aref_interval(aref_interval),
    .trfc(trfc), .ref_ack(ref_ack), .ref_req(ref_req), .ref_busy(ref_busy),
    .ref_urgent(ref_urgent), .ref_overrun(ref_overrun), .pend_cnt(pend_cnt),
    .ref_count(ref_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;
  bit auto_ack = 1'b0;

  // Reference model: refresh is requested whenever something is owed and no
  // blackout is running; ticks fall every aref_interval enabled cycles.
  int     m_pend, m_busy_left, m_count;
  bit     m_req, m_ovr, m_tick, m_acc;
  longint m_run;

  always @(posedge clk) begin
    if (rst) begin
      m_pend = 0; m_busy_left = 0; m_count = 0;
      m_req = 0; m_ovr = 0; m_run = 0;
    end else begin
      m_acc = ref_ack && m_req;
      if (aref_en && aref_interval != 0) m_run = m_run + 1;
      else m_run = 0;
      m_tick = (aref_interval != 0) && (m_run != 0) && (m_run % aref_interval == 0);
      if (!aref_en) m_pend = 0;
      else if (m_tick && !m_acc) begin
        if (m_pend == MAXP) m_ovr = 1;
        else m_pend = m_pend + 1;
      end else if (m_acc && !m_tick && m_pend > 0) m_pend = m_pend - 1;
`ifdef AREF_STATS_EN
      if (m_acc) m_count = (m_count + 1) % 65536;
`endif
      if (m_acc) m_busy_left = (trfc == 0) ? 1 : int'(trfc);
      else if (m_busy_left > 0) m_busy_left = m_busy_left - 1;
      m_req = (m_busy_left == 0) && (m_pend > 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("ref_req", 32'(ref_req), 32'(m_req));
      chk("ref_busy", 32'(ref_busy), 32'(m_busy_left > 0));
      chk("ref_urgent", 32'(ref_urgent), 32'(m_pend == MAXP));
      chk("ref_overrun", 32'(ref_overrun), 32'(m_ovr));
      chk("pend_cnt", 32'(pend_cnt), 32'(m_pend));
      chk("ref_count", 32'(ref_count), 32'(m_count));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      ref_ack = auto_ack && m_req;
    end
  endtask

  int exp_cnt;

  initial begin
    repeat (3) @(negedge clk);
    checking = 1'b1;
    chk("rst_req", 32'(ref_req), 0);
    chk("rst_busy", 32'(ref_busy), 0);
    chk("rst_pend", 32'(pend_cnt), 0);
    chk("rst_count", 32'(ref_count), 0);
    rst = 1'b0;

    // Regular refresh: tREFI=100, tRFC=10, immediate grants.
    aref_interval = 28'd100; trfc = 28'd10; auto_ack = 1'b1; aref_en = 1'b1;
    step(99);
    chk("first_req_early", 32'(ref_req), 0);
    step(1);
    chk("first_req", 32'(ref_req), 1);
    step(1);
    chk("first_busy", 32'(ref_busy), 1);
    chk("first_pend", 32'(pend_cnt), 0);
    step(420);
`ifdef AREF_STATS_EN
    exp_cnt = 5;
`else
    exp_cnt = 0;
`endif
    chk("count_after_5", 32'(ref_count), 32'(exp_cnt));
    chk("pend_after_5", 32'(pend_cnt), 0);

    // Withheld grants: saturate, overrun, then drain.
    aref_en = 1'b0; auto_ack = 1'b0; ref_ack = 1'b0;
    step(2);
    aref_interval = 28'd20; trfc = 28'd2; aref_en = 1'b1;
    step(160);
    chk("sat_pend", 32'(pend_cnt), 8);
    chk("sat_urgent", 32'(ref_urgent), 1);
    chk("sat_ovr_clear", 32'(ref_overrun), 0);
    step(20);
    chk("ovr_set", 32'(ref_overrun), 1);
    chk("ovr_pend", 32'(pend_cnt), 8);
    auto_ack = 1'b1;
    step(80);
    chk("ovr_sticky", 32'(ref_overrun), 1);

    // Tick and ack coincide with three refreshes owed.
    aref_en = 1'b0; auto_ack = 1'b0; ref_ack = 1'b0;
    step(5);
    aref_interval = 28'd20; trfc = 28'd4; aref_en = 1'b1;
    step(79);
    chk("pre_coinc_pend", 32'(pend_cnt), 3);
    ref_ack = 1'b1;
    step(1);
    chk("coinc_pend", 32'(pend_cnt), 3);
    chk("coinc_busy", 32'(ref_busy), 1);

    // Stray acks in TRFC and IDLE, then trfc=0.
    aref_en = 1'b0; ref_ack = 1'b0;
    step(6);
    aref_interval = 28'd20; trfc = 28'd3; aref_en = 1'b1;
    step(20);
    chk("s4_req", 32'(ref_req), 1);
    ref_ack = 1'b1;
    step(1);
    chk("s4_busy", 32'(ref_busy), 1);
    chk("s4_pend", 32'(pend_cnt), 0);
    ref_ack = 1'b1;
    step(1);
    chk("stray_busy_pend", 32'(pend_cnt), 0);
    step(5);
    chk("s4_idle_busy", 32'(ref_busy), 0);
    chk("s4_idle_req", 32'(ref_req), 0);
    ref_ack = 1'b1;
    step(1);
    chk("stray_idle_pend", 32'(pend_cnt), 0);
    trfc = 28'd0; auto_ack = 1'b1;
    step(12);
    chk("t0_req", 32'(ref_req), 1);
    step(1);
    chk("t0_busy_on", 32'(ref_busy), 1);
    step(1);
    chk("t0_busy_off", 32'(ref_busy), 0);

    // Enable dropped during TRFC and during REQ.
    aref_en = 1'b0; auto_ack = 1'b0; ref_ack = 1'b0;
    step(3);
    trfc = 28'd10; aref_en = 1'b1;
    step(60);
    chk("s5_pend3", 32'(pend_cnt), 3);
    ref_ack = 1'b1;
    step(1);
    chk("s5_pend2", 32'(pend_cnt), 2);
    chk("s5_busy", 32'(ref_busy), 1);
    aref_en = 1'b0;
    step(1);
    chk("s5_pend_clr", 32'(pend_cnt), 0);
    chk("s5_busy_holds", 32'(ref_busy), 1);
    step(12);
    chk("s5_done_busy", 32'(ref_busy), 0);
    chk("s5_done_req", 32'(ref_req), 0);
    aref_en = 1'b1;
    step(20);
    chk("s5_req", 32'(ref_req), 1);
    aref_en = 1'b0;
    step(1);
    chk("s5_req_drop", 32'(ref_req), 0);

    // Reset in the middle of a blackout.
    aref_en = 1'b1;
    step(20);
    ref_ack = 1'b1;
    step(3);
    chk("s6_busy", 32'(ref_busy), 1);
    chk("s6_ovr", 32'(ref_overrun), 1);
    rst = 1'b1;
    step(1);
    chk("s6_rst_busy", 32'(ref_busy), 0);
    chk("s6_rst_ovr", 32'(ref_overrun), 0);
    chk("s6_rst_req", 32'(ref_req), 0);
    chk("s6_rst_pend", 32'(pend_cnt), 0);
    chk("s6_rst_count", 32'(ref_count), 0);
    rst = 1'b0; aref_en = 1'b0;
    step(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
